// File: rtl/mem_loader_pkg.sv
// Shared definitions for the framed-stream memory loader: command codes,
// FSM state encoding and frame capacity helper.
package mem_loader_pkg;

    localparam int LEN_W = 12;

    localparam logic [7:0] CMD_INST = 8'h01;
    localparam logic [7:0] CMD_DATA = 8'h02;
    localparam logic [7:0] CMD_DONE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_PAYLOAD,
        ST_COOL,
        ST_RUN,
        ST_ERR
    } state_e;

    typedef enum logic {
        TGT_INST,
        TGT_DATA
    } tgt_e;

    // Bytes a single frame may carry without running past the top of memory.
    function automatic int frame_cap(input tgt_e tgt, input int addr_w, input int data_base);
        return (tgt == TGT_DATA) ? (1 << addr_w) - data_base : (1 << addr_w);
    endfunction

endpackage

// File: rtl/mem_loader_wport.sv
// Registered memory write port: a load-able address pointer plus one-cycle
// strobe, address and data registers driven towards one memory.
module mem_loader_wport #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              we,
    input  logic [7:0]        wdata,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wr_data,
    output logic              wr
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_q, wr_d;

    always_comb begin
        ptr_d  = ptr_q;
        addr_d = addr_q;
        data_d = data_q;
        wr_d   = 1'b0;
        if (load) begin
            ptr_d  = load_addr;
            addr_d = load_addr;
        end else if (we) begin
            addr_d = ptr_q;
            data_d = wdata;
            wr_d   = 1'b1;
            ptr_d  = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ptr_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            wr_q   <= wr_d;
        end
    end

    assign addr    = addr_q;
    assign wr_data = data_q;
    assign wr      = wr_q;

endmodule

// File: rtl/mem_loader.sv
// Frame parser that streams bytes into instruction/data memory, then holds
// the CPU in reset for a cool-off interval after DONE before releasing it.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_BASE   = 8,
    parameter int COOL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] i_addr,
    output logic [7:0]        i_wr_data,
    output logic              i_wr,
    output logic [ADDR_W-1:0] d_addr,
    output logic [7:0]        d_wr_data,
    output logic              d_wr,
    output logic              loading,
    output logic              cpu_reset_,
    output logic              err
);

    localparam int CAP_INST = frame_cap(TGT_INST, ADDR_W, DATA_BASE);
    localparam int CAP_DATA = frame_cap(TGT_DATA, ADDR_W, DATA_BASE);
    localparam int COOL_W   = $clog2(COOL_CYCLES + 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOL_CYCLES - 1);

    state_e            state_q, state_d;
    tgt_e              tgt_q, tgt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [COOL_W-1:0] cool_q, cool_d;
    logic              in_ready_q, in_ready_d;
    logic              loading_q, loading_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              err_q, err_d;

    logic              acc;
    logic [LEN_W-1:0]  len_full;
    logic              i_load, d_load, i_we, d_we;

    assign acc      = in_valid & in_ready_q;
    assign len_full = {len_q[LEN_W-1:8], in_data};

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        len_d   = len_q;
        cool_d  = cool_q;
        i_load  = 1'b0;
        d_load  = 1'b0;
        i_we    = 1'b0;
        d_we    = 1'b0;
        case (state_q)
            ST_IDLE: if (acc) begin
                case (in_data)
                    CMD_INST: begin tgt_d = TGT_INST; state_d = ST_LEN_HI; end
                    CMD_DATA: begin tgt_d = TGT_DATA; state_d = ST_LEN_HI; end
                    CMD_DONE: begin cool_d = '0;      state_d = ST_COOL;   end
                    default:  state_d = ST_ERR;
                endcase
            end
            ST_LEN_HI: if (acc) begin
                if (in_data[7:4] != 4'h0) begin
                    state_d = ST_ERR;
                end else begin
                    len_d   = {in_data[3:0], 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: if (acc) begin
                if (len_full == '0) begin
                    state_d = ST_IDLE;
                end else if (int'(len_full) > ((tgt_q == TGT_DATA) ? CAP_DATA : CAP_INST)) begin
                    state_d = ST_ERR;
                end else begin
                    len_d   = len_full;
                    i_load  = (tgt_q == TGT_INST);
                    d_load  = (tgt_q == TGT_DATA);
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: if (acc) begin
                i_we  = (tgt_q == TGT_INST);
                d_we  = (tgt_q == TGT_DATA);
                len_d = len_q - 1'b1;
                if (len_q == LEN_W'(1)) state_d = ST_IDLE;
            end
            ST_COOL: begin
                if (cool_q == COOL_LAST) state_d = ST_RUN;
                else                     cool_d  = cool_q + 1'b1;
            end
            default: ;
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LEN_HI) ||
                      (state_d == ST_LEN_LO) || (state_d == ST_PAYLOAD);
        loading_d   = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                      (state_d == ST_PAYLOAD) || i_we || d_we;
        cpu_reset_d = (state_d == ST_RUN);
        err_d       = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            tgt_q       <= TGT_INST;
            len_q       <= '0;
            cool_q      <= '0;
            in_ready_q  <= 1'b0;
            loading_q   <= 1'b0;
            cpu_reset_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            len_q       <= len_d;
            cool_q      <= cool_d;
            in_ready_q  <= in_ready_d;
            loading_q   <= loading_d;
            cpu_reset_q <= cpu_reset_d;
            err_q       <= err_d;
        end
    end

    mem_loader_wport #(.ADDR_W(ADDR_W)) u_iport (
        .clk       (clk),
        .reset_    (reset_),
        .load      (i_load),
        .load_addr ('0),
        .we        (i_we),
        .wdata     (in_data),
        .addr      (i_addr),
        .wr_data   (i_wr_data),
        .wr        (i_wr)
    );

    mem_loader_wport #(.ADDR_W(ADDR_W)) u_dport (
        .clk       (clk),
        .reset_    (reset_),
        .load      (d_load),
        .load_addr (ADDR_W'(DATA_BASE)),
        .we        (d_we),
        .wdata     (in_data),
        .addr      (d_addr),
        .wr_data   (d_wr_data),
        .wr        (d_wr)
    );

    assign in_ready   = in_ready_q;
    assign loading    = loading_q;
    assign cpu_reset_ = cpu_reset_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: frames, gaps, DONE cool-off, error cases,
// max-length frame and asynchronous abort.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [11:0] i_addr, d_addr;
    logic [7:0]  i_wr_data, d_wr_data;
    logic        i_wr, d_wr, loading, cpu_reset_, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int ilog_addr[$], ilog_data[$], ilog_cyc[$];
    int dlog_addr[$], dlog_data[$], dlog_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (i_wr) begin ilog_addr.push_back(i_addr); ilog_data.push_back(i_wr_data); ilog_cyc.push_back(cyc); end
        if (d_wr) begin dlog_addr.push_back(d_addr); dlog_data.push_back(d_wr_data); dlog_cyc.push_back(cyc); end
    end

    mem_loader dut (
        .clk        (clk),
        .reset_     (reset_),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .i_addr     (i_addr),
        .i_wr_data  (i_wr_data),
        .i_wr       (i_wr),
        .d_addr     (d_addr),
        .d_wr_data  (d_wr_data),
        .d_wr       (d_wr),
        .loading    (loading),
        .cpu_reset_ (cpu_reset_),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        ilog_addr.delete(); ilog_data.delete(); ilog_cyc.delete();
        dlog_addr.delete(); dlog_data.delete(); dlog_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_   = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    // Holds the byte until it is taken; an expired bound counts as a failure.
    task automatic send(input logic [7:0] b);
        logic took;
        took = 1'b0;
        for (int t = 0; t < 50 && !took; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            took     = in_ready;
            @(posedge clk);
        end
        if (!took) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    int n;
    int bad;

    initial begin
        // reset state
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cpu_reset", cpu_reset_, 0);
        chk("rst_err", err, 0);
        chk("rst_i_wr", i_wr, 0);
        chk("rst_loading", loading, 0);
        chk("rst_i_addr", i_addr, 0);
        chk("rst_d_wr_data", d_wr_data, 0);
        do_reset();
        chk("post_rst_in_ready", in_ready, 1);

        // INST frame, back-to-back payload
        send(8'h01); #1;
        chk("inst_loading", loading, 1);
        send(8'h00); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        idle(3);
        chk("inst_count", ilog_addr.size(), 3);
        if (ilog_addr.size() == 3) begin
            chk("inst_a0", ilog_addr[0], 0); chk("inst_d0", ilog_data[0], 8'hAA);
            chk("inst_a1", ilog_addr[1], 1); chk("inst_d1", ilog_data[1], 8'hBB);
            chk("inst_a2", ilog_addr[2], 2); chk("inst_d2", ilog_data[2], 8'hCC);
            chk("inst_b2b", ilog_cyc[2] - ilog_cyc[0], 2);
        end
        chk("inst_no_dwr", dlog_addr.size(), 0);
        chk("inst_idle_ready", in_ready, 1);
        chk("inst_idle_loading", loading, 0);

        // DATA frame with a gap between payload bytes
        clear_logs();
        send(8'h02); send(8'h00); send(8'h02);
        send(8'h11); idle(1); send(8'h22);
        idle(3);
        chk("data_count", dlog_addr.size(), 2);
        if (dlog_addr.size() == 2) begin
            chk("data_a0", dlog_addr[0], 8); chk("data_d0", dlog_data[0], 8'h11);
            chk("data_a1", dlog_addr[1], 9); chk("data_d1", dlog_data[1], 8'h22);
            chk("data_gap", dlog_cyc[1] - dlog_cyc[0], 2);
        end
        chk("data_no_iwr", ilog_addr.size(), 0);
        chk("data_i_addr_hold", i_addr, 2);
        chk("data_i_data_hold", i_wr_data, 8'hCC);

        // zero-length frame
        clear_logs();
        send(8'h01); send(8'h00); send(8'h00);
        idle(3);
        chk("zero_no_wr", ilog_addr.size() + dlog_addr.size(), 0);
        chk("zero_ready", in_ready, 1);
        chk("zero_loading", loading, 0);

        // maximum INST frame
        clear_logs();
        send(8'h01); send(8'h0F); send(8'hFF);
        for (int i = 0; i < 4095; i++) send(8'(i));
        idle(2);
        chk("big_count", ilog_addr.size(), 4095);
        bad = 0;
        foreach (ilog_addr[k]) if (ilog_addr[k] != k || ilog_data[k] != (k & 255)) bad++;
        chk("big_pattern", bad, 0);
        if (ilog_addr.size() > 0) chk("big_last_addr", ilog_addr[ilog_addr.size()-1], 12'hFFE);
        chk("big_err", err, 0);

        // DONE and cool-off
        send(8'hFF); #1;
        chk("done_ready_drop", in_ready, 0);
        chk("done_cpu_low", cpu_reset_, 0);
        n = 0;
        while (!cpu_reset_ && n < 100) begin @(posedge clk); #1; n++; end
        chk("cool_cycles", n, 32);
        clear_logs();
        @(negedge clk); in_valid = 1'b1; in_data = 8'h01;
        repeat (10) @(posedge clk);
        #1;
        chk("run_ready", in_ready, 0);
        chk("run_cpu_high", cpu_reset_, 1);
        chk("run_no_wr", ilog_addr.size() + dlog_addr.size(), 0);

        // bad command
        do_reset();
        send(8'h07); #1;
        chk("badcmd_err", err, 1);
        chk("badcmd_ready", in_ready, 0);
        idle(40); #1;
        chk("badcmd_cpu", cpu_reset_, 0);
        chk("badcmd_err_sticky", err, 1);

        // DATA over capacity
        do_reset();
        send(8'h02); send(8'h0F); send(8'hF9); #1;
        chk("dcap_err", err, 1);
        chk("dcap_loading", loading, 0);

        // LEN_HI upper nibble set
        do_reset();
        send(8'h01); send(8'h10); #1;
        chk("lenhi_err", err, 1);

        // DONE with no prior frames is legal
        do_reset();
        send(8'hFF); idle(40); #1;
        chk("done_only_cpu", cpu_reset_, 1);
        chk("done_only_err", err, 0);

        // async abort mid-payload, then a fresh frame
        do_reset();
        send(8'h01); send(8'h00); send(8'h0A);
        send(8'h31); send(8'h32); send(8'h33);
        #1;
        chk("abort_pre_wr", i_wr, 1);
        #2;
        reset_ = 1'b0;
        #1;
        chk("abort_i_wr", i_wr, 0);
        chk("abort_i_addr", i_addr, 0);
        chk("abort_i_data", i_wr_data, 0);
        chk("abort_loading", loading, 0);
        chk("abort_ready", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk); reset_ = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        send(8'h01); send(8'h00); send(8'h01); send(8'h5A);
        idle(2);
        chk("fresh_count", ilog_addr.size(), 1);
        if (ilog_addr.size() == 1) begin
            chk("fresh_addr", ilog_addr[0], 0);
            chk("fresh_data", ilog_data[0], 8'h5A);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Synthesizable program/data loader that sits between a byte-stream source (host link or bench driver) and the instruction and data memories.
- Parses a framed byte stream and issues write strobes to the instruction memory (base 0) or data memory (base DATA_BASE; addresses 0-7 are special-purpose).
- After a DONE command, counts a cool-off interval and then releases the CPU reset.
- Replaces the file-driven programming and cool-off logic currently done behaviourally.

Parameters:
ADDR_W, 12, memory address width (4096 bytes per memory)
DATA_BASE, 8, first data-memory address written by a data load
COOL_CYCLES, 32, cycles between DONE acceptance and cpu_reset_ deassertion (min 1)

Ports:
clk  in  1  system clock
reset_  in  1  asynchronous active-low reset
in_valid  in  1  stream byte valid
in_data  in  8  stream byte
in_ready  out  1  loader accepts byte; transfer when in_valid & in_ready
i_addr  out  ADDR_W  instruction memory write address
i_wr_data  out  8  instruction memory write data
i_wr  out  1  instruction memory write strobe, one cycle per byte
d_addr  out  ADDR_W  data memory write address
d_wr_data  out  8  data memory write data
d_wr  out  1  data memory write strobe, one cycle per byte
loading  out  1  high while a frame is being parsed or written
cpu_reset_  out  1  active-low CPU reset; high only in RUN
err  out  1  sticky protocol error

Behaviour:
- Reset values (async, reset_ low): state IDLE; in_ready=0 during reset, 1 first cycle after; i_wr=d_wr=0; addresses=0; write data=0; loading=0; cpu_reset_=0; err=0; length and cool counters=0.
- Frame format: CMD byte, LEN_HI byte (low 4 bits used, upper 4 must be 0), LEN_LO byte, then LEN payload bytes. LEN is 12 bits.
- CMD encodings: 0x01 = INST, 0x02 = DATA, 0xFF = DONE. DONE has no length bytes.
- States and transitions:
  - IDLE: in_ready=1. On accept: CMD=INST/DATA -> LEN_HI, latch target. CMD=DONE -> COOL. Any other CMD -> ERR.
  - LEN_HI: accept -> LEN_LO. Nonzero upper nibble -> ERR.
  - LEN_LO: accept, form LEN.
    - LEN=0 -> IDLE.
    - LEN > capacity -> ERR. Capacity is 4096 for INST, 4096-DATA_BASE for DATA.
    - Otherwise -> PAYLOAD; load address with 0 (INST) or DATA_BASE (DATA).
  - PAYLOAD: in_ready=1. Byte accepted in cycle N produces a write strobe, address and data registered, visible in cycle N+1. Address increments after each write. Back-to-back bytes give consecutive strobes. in_valid gaps insert idle cycles with no strobe. After the LEN-th byte -> IDLE.
  - COOL: in_ready=0; counter counts COOL_CYCLES cycles, then -> RUN.
  - RUN: cpu_reset_=1, in_ready=0; terminal until reset.
  - ERR: err=1, in_ready=0, cpu_reset_=0, no strobes; terminal until reset.
- loading=1 in LEN_HI, LEN_LO, PAYLOAD and during the trailing write cycle; 0 otherwise.
- Only one of i_wr/d_wr is ever high. The non-targeted memory's outputs hold their values.
- Address never wraps: the capacity check guarantees the final address is at most 12'hfff.
- Multiple INST/DATA frames may precede DONE. Later frames restart at the base address and overwrite earlier data.
- A DONE with no prior frames is legal.
- reset_ asserted mid-payload aborts immediately. Strobes drop asynchronously and partial contents are not rolled back.

Decomposition:
- Shared package/header: CMD_INST, CMD_DATA, CMD_DONE constants; state encodings (IDLE, LEN_HI, LEN_LO, PAYLOAD, COOL, RUN, ERR); capacity constants derived from ADDR_W and DATA_BASE.
- Natural sub-module: mem_loader_wport, a registered write port (address counter plus strobe/data register), instantiated twice, once per memory.

Test Plan:
- Reset, then stream 01 00 03 AA BB CC -> i_wr pulses 3 cycles at i_addr 0,1,2 with data AA,BB,CC; d_wr stays 0; state returns to IDLE.
- Stream 02 00 02 11 22 with one idle in_valid cycle between payload bytes -> d_wr at d_addr 8 (11) and 9 (22), with one gap cycle between strobes.
- Send FF -> in_ready drops the next cycle; cpu_reset_ rises exactly COOL_CYCLES=32 cycles after DONE acceptance; later bytes are never accepted.
- Send 07 -> err=1, in_ready=0; cpu_reset_ stays 0 until reset. Separately, send 02 0F F9 (4089 > 4088) -> err.
- Send 01 0F FF + 4095 bytes -> final write at i_addr 12'hffe; send 01 10 00 -> err (length 4096 is encoded with LEN_HI=0x10, which has a nonzero upper nibble); send 01 00 00 -> no strobes, back to IDLE.
- Assert reset_ mid-payload of a 10-byte INST frame -> i_wr drops asynchronously and all outputs return to reset values; a fresh frame after release loads from address 0.
